// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pkg
//  Description : Shared definitions for the SD Wishbone DMA arbiter:
//                sequencer state encoding, Wishbone CTI/BTE codes and the
//                maximum burst length (one 512-byte block of 32-bit words).
//  Revision    : 1.0  initial release
// ============================================================================
package sd_pkg;

    localparam int          MAX_BEATS  = 128;
    localparam logic [2:0]  CTI_INCR   = 3'b010;
    localparam logic [2:0]  CTI_END    = 3'b111;
    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [1:0]  BTE_LINEAR = 2'b00;
    localparam logic [3:0]  SEL_ALL    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_BURST = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sd_wb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : sd_wb_rr
//  Description : Two-way round-robin grant selector. A lone request wins
//                outright; on contention the pointer side wins. The pointer
//                moves to the losing side whenever a grant is taken.
//  Revision    : 1.0  initial release
// ============================================================================
module sd_wb_rr (
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic take_i,
    output logic valid_o,
    output logic sel_o
);

    logic ptr_q;
    logic ptr_d;

    // Winner selection and pointer update on a taken grant.
    always_comb begin
        valid_o = req0_i | req1_i;
        sel_o   = (req0_i & req1_i) ? ptr_q : req1_i;
        ptr_d   = ptr_q;
        if (take_i && valid_o) begin
            ptr_d = ~sel_o;
        end
    end

    // Pointer register; starts favouring requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sd_wb_arb
//  Description : Shares one Wishbone master between the SD read-fill (rq0)
//                and write-drain (rq1) DMA paths. Each grant runs a single
//                incrementing burst of up to MAX_BEATS words and drives a
//                lookahead BRAM address so registered-output BRAMs stream
//                without strobe bubbles.
//                Optional ack timeout: define SD_WB_ARB_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module sd_wb_arb #(
    parameter int MAX_BEATS   = sd_pkg::MAX_BEATS,
    parameter int IDX_W       = 7,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              rq0_req,
    input  logic              rq0_we,
    input  logic [31:0]       rq0_adr,
    input  logic [7:0]        rq0_len,
    input  logic [31:0]       rq0_wdat,
    output logic              rq0_gnt,
    output logic              rq0_done,
    output logic              rq0_err,
    input  logic              rq1_req,
    input  logic              rq1_we,
    input  logic [31:0]       rq1_adr,
    input  logic [7:0]        rq1_len,
    input  logic [31:0]       rq1_wdat,
    output logic              rq1_gnt,
    output logic              rq1_done,
    output logic              rq1_err,
    output logic [IDX_W-1:0]  bram_addr,
    output logic              rd_wren,
    output logic [IDX_W-1:0]  rd_addr,
    output logic [31:0]       rd_dat,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    output logic [3:0]        wbm_sel_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [2:0]        wbm_cti_o,
    output logic [1:0]        wbm_bte_o,
    input  logic              wbm_ack_i,
    input  logic [31:0]       wbm_dat_i
);

    // One extra bit so the index can reach MAX_BEATS itself.
    localparam int CNT_W = IDX_W + 1;

    // Elaboration-time sanity check on the configuration.
    if (((1 << IDX_W) != MAX_BEATS) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("sd_wb_arb: IDX_W must equal log2(MAX_BEATS) and TIMEOUT_CYC >= 1");
    end

    sd_pkg::state_t   state_q, state_d;
    logic             sel_q, sel_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             rd_wren_q, rd_wren_d;
    logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
    logic [31:0]      rd_dat_q, rd_dat_d;

    logic             w_valid;
    logic             w_sel;
    logic             w_take;
    logic             w_burst;
    logic             w_ack;
    logic             w_last;
    logic             w_to;
    logic             w_active;
    logic [7:0]       w_len_raw;
    logic [7:0]       w_len_clamp;

    sd_wb_rr u_rr (
        .clk     (clk_50),
        .rst     (reset),
        .req0_i  (rq0_req),
        .req1_i  (rq1_req),
        .take_i  (w_take),
        .valid_o (w_valid),
        .sel_o   (w_sel)
    );

    assign w_take      = (state_q == sd_pkg::ST_IDLE) & w_valid;
    assign w_burst     = (state_q == sd_pkg::ST_BURST);
    assign w_ack       = w_burst & wbm_ack_i;
    assign w_last      = (idx_q == (len_q - CNT_W'(1)));
    assign w_active    = (state_q != sd_pkg::ST_IDLE);
    assign w_len_raw   = w_sel ? rq1_len : rq0_len;
    assign w_len_clamp = (w_len_raw > 8'(MAX_BEATS)) ? 8'(MAX_BEATS) : w_len_raw;

`ifdef SD_WB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Count consecutive un-acked burst cycles; cleared outside BURST and on ack.
    always_comb begin
        tmo_d = '0;
        if (w_burst && !wbm_ack_i) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    assign w_to = w_burst & ~wbm_ack_i & (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Timeout counter register.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign rq0_err = (state_q == sd_pkg::ST_ERR) & ~sel_q;
    assign rq1_err = (state_q == sd_pkg::ST_ERR) &  sel_q;
`else
    assign w_to    = 1'b0;
    assign rq0_err = 1'b0;
    assign rq1_err = 1'b0;
`endif

    // Burst sequencer: grant latch, beat indexing and state transitions.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        adr_d   = adr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        case (state_q)
            sd_pkg::ST_IDLE: begin
                if (w_valid) begin
                    sel_d   = w_sel;
                    we_d    = w_sel ? rq1_we  : rq0_we;
                    adr_d   = w_sel ? rq1_adr : rq0_adr;
                    len_d   = w_len_clamp[CNT_W-1:0];
                    idx_d   = '0;
                    state_d = sd_pkg::ST_SETUP;
                end
            end
            sd_pkg::ST_SETUP: begin
                state_d = (len_q == '0) ? sd_pkg::ST_DONE : sd_pkg::ST_BURST;
            end
            sd_pkg::ST_BURST: begin
                if (w_ack) begin
                    idx_d = idx_q + CNT_W'(1);
                    if (w_last) begin
                        state_d = sd_pkg::ST_DONE;
                    end
                end else if (w_to) begin
                    state_d = sd_pkg::ST_ERR;
                end
            end
            sd_pkg::ST_DONE: state_d = sd_pkg::ST_IDLE;
            sd_pkg::ST_ERR:  state_d = sd_pkg::ST_IDLE;
            default:         state_d = sd_pkg::ST_IDLE;
        endcase
    end

    // Read-burst capture: write strobe, BRAM index and data one cycle after ack.
    always_comb begin
        rd_wren_d = w_ack & ~we_q;
        rd_addr_d = rd_addr_q;
        rd_dat_d  = rd_dat_q;
        if (rd_wren_d) begin
            rd_addr_d = idx_q[IDX_W-1:0];
            rd_dat_d  = wbm_dat_i;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q   <= sd_pkg::ST_IDLE;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rd_wren_q <= 1'b0;
            rd_addr_q <= '0;
            rd_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_dat_q  <= rd_dat_d;
        end
    end

    // Lookahead: on an acked beat the BRAM must already fetch the next word.
    assign bram_addr = w_ack ? IDX_W'(idx_q + CNT_W'(1)) : idx_q[IDX_W-1:0];

    assign rd_wren   = rd_wren_q;
    assign rd_addr   = rd_addr_q;
    assign rd_dat    = rd_dat_q;

    assign rq0_gnt   = w_active & ~sel_q;
    assign rq1_gnt   = w_active &  sel_q;
    assign rq0_done  = (state_q == sd_pkg::ST_DONE) & ~sel_q;
    assign rq1_done  = (state_q == sd_pkg::ST_DONE) &  sel_q;

    assign wbm_cyc_o = w_burst;
    assign wbm_stb_o = w_burst;
    assign wbm_we_o  = w_burst & we_q;
    assign wbm_adr_o = w_burst ? (adr_q + {{(32-CNT_W-2){1'b0}}, idx_q, 2'b00}) : 32'h0;
    assign wbm_dat_o = w_burst ? (sel_q ? rq1_wdat : rq0_wdat) : 32'h0;
    assign wbm_cti_o = w_burst ? (w_last ? sd_pkg::CTI_END : sd_pkg::CTI_INCR)
                               : sd_pkg::CTI_CLASSIC;
    assign wbm_sel_o = sd_pkg::SEL_ALL;
    assign wbm_bte_o = sd_pkg::BTE_LINEAR;

endmodule
`default_nettype wire

// File: tb/tb_sd_wb_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sd_wb_arb
//  Description : Directed self-checking bench for sd_wb_arb. The ack-timeout
//                scenario runs only when SD_WB_ARB_TIMEOUT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sd_wb_arb;

    localparam int IDX_W = 7;

    logic             clk_50 = 1'b0;
    logic             reset;
    logic             rq0_req, rq0_we, rq1_req, rq1_we;
    logic [31:0]      rq0_adr, rq1_adr, rq0_wdat, rq1_wdat;
    logic [7:0]       rq0_len, rq1_len;
    logic             rq0_gnt, rq0_done, rq0_err, rq1_gnt, rq1_done, rq1_err;
    logic [IDX_W-1:0] bram_addr, rd_addr;
    logic             rd_wren;
    logic [31:0]      rd_dat, wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]       wbm_sel_o;
    logic             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [2:0]       wbm_cti_o;
    logic [1:0]       wbm_bte_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [0:127];
    logic [31:0] bram_q;

    sd_wb_arb #(.MAX_BEATS(128), .IDX_W(IDX_W), .TIMEOUT_CYC(16)) dut (
        .clk_50(clk_50), .reset(reset),
        .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_adr(rq0_adr), .rq0_len(rq0_len),
        .rq0_wdat(rq0_wdat), .rq0_gnt(rq0_gnt), .rq0_done(rq0_done), .rq0_err(rq0_err),
        .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_adr(rq1_adr), .rq1_len(rq1_len),
        .rq1_wdat(rq1_wdat), .rq1_gnt(rq1_gnt), .rq1_done(rq1_done), .rq1_err(rq1_err),
        .bram_addr(bram_addr), .rd_wren(rd_wren), .rd_addr(rd_addr), .rd_dat(rd_dat),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk_50 = ~clk_50;

    // Registered-output BRAM model feeding the write-drain requester.
    always @(posedge clk_50) bram_q <= mem[bram_addr];
    assign rq1_wdat = bram_q;
    assign rq0_wdat = 32'h0BAD_F00D;

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        @(negedge clk_50);
        vectors++;
        if ({rq0_gnt, rq1_gnt, rq0_done, rq1_done, rq0_err, rq1_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_req_side: got %b required 000000",
                     {rq0_gnt, rq1_gnt, rq0_done, rq1_done, rq0_err, rq1_err});
        end
        vectors++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_adr_o, wbm_dat_o} !== 70'h0) begin
            miscompares++;
            $display("FAIL reset_wb: cyc %b stb %b we %b cti %h adr %h dat %h required all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_adr_o, wbm_dat_o);
        end
        vectors++;
        if (wbm_sel_o !== 4'hF || wbm_bte_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_sel_bte: sel %h bte %b required F 00", wbm_sel_o, wbm_bte_o);
        end
        vectors++;
        if (bram_addr !== 7'd0 || rd_wren !== 1'b0 || rd_addr !== 7'd0 || rd_dat !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_bram: bram_addr %h rd_wren %b rd_addr %h rd_dat %h required 0",
                     bram_addr, rd_wren, rd_addr, rd_dat);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_read_burst();
        rq0_we = 1'b0; rq0_adr = 32'h0000_1000; rq0_len = 8'd4; rq0_req = 1'b1;
        wbm_ack_i = 1'b1;
        step();
        @(negedge clk_50);
        vectors++;
        if (rq0_gnt !== 1'b1 || rq1_gnt !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_grant: gnt0 %b gnt1 %b cyc %b required 1 0 0", rq0_gnt, rq1_gnt, wbm_cyc_o);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            wbm_dat_i = 32'hCAFE_0000 + k;
            @(negedge clk_50);
            vectors++;
            if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b110 || wbm_adr_o !== 32'h1000 + 4 * k) begin
                miscompares++;
                $display("FAIL rd_beat%0d_adr: cyc/stb/we %b adr %h required 110 %h",
                         k, {wbm_cyc_o, wbm_stb_o, wbm_we_o}, wbm_adr_o, 32'h1000 + 4 * k);
            end
            vectors++;
            if (wbm_cti_o !== ((k == 3) ? 3'b111 : 3'b010)) begin
                miscompares++;
                $display("FAIL rd_beat%0d_cti: got %b required %b", k, wbm_cti_o,
                         (k == 3) ? 3'b111 : 3'b010);
            end
            vectors++;
            if (bram_addr !== 7'(k + 1)) begin
                miscompares++;
                $display("FAIL rd_beat%0d_bram_addr: got %0d required %0d", k, bram_addr, k + 1);
            end
            if (k > 0) begin
                vectors++;
                if (rd_wren !== 1'b1 || rd_addr !== 7'(k - 1) || rd_dat !== 32'hCAFE_0000 + k - 1) begin
                    miscompares++;
                    $display("FAIL rd_beat%0d_capture: wren %b addr %0d dat %h required 1 %0d %h",
                             k, rd_wren, rd_addr, rd_dat, k - 1, 32'hCAFE_0000 + k - 1);
                end
            end
            step();
        end
        @(negedge clk_50);
        vectors++;
        if (rq0_done !== 1'b1 || rq0_gnt !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_done: done %b gnt %b cyc %b required 1 1 0", rq0_done, rq0_gnt, wbm_cyc_o);
        end
        vectors++;
        if (rd_wren !== 1'b1 || rd_addr !== 7'd3 || rd_dat !== 32'hCAFE_0003) begin
            miscompares++;
            $display("FAIL rd_last_capture: wren %b addr %0d dat %h required 1 3 cafe0003",
                     rd_wren, rd_addr, rd_dat);
        end
        rq0_req = 1'b0;
        step();
        @(negedge clk_50);
        vectors++;
        if (rq0_gnt !== 1'b0 || rq0_done !== 1'b0 || rd_wren !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_release: gnt %b done %b wren %b required 0 0 0", rq0_gnt, rq0_done, rd_wren);
        end
        step();
    endtask

    task automatic test_write_burst();
        logic [31:0] exp_adr;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        rq1_we = 1'b1; rq1_adr = 32'hFFFF_FF00; rq1_len = 8'd128; rq1_req = 1'b1;
        wbm_ack_i = 1'b1;
        step();
        step();
        for (int k = 0; k < 128; k++) begin
            exp_adr = 32'hFFFF_FF00 + 32'(4 * k);
            @(negedge clk_50);
            vectors++;
            if (wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_dat_o !== mem[k] || wbm_adr_o !== exp_adr) begin
                miscompares++;
                $display("FAIL wr_beat%0d: stb %b we %b dat %h adr %h required 1 1 %h %h",
                         k, wbm_stb_o, wbm_we_o, wbm_dat_o, wbm_adr_o, mem[k], exp_adr);
            end
            step();
        end
        @(negedge clk_50);
        vectors++;
        if (rq1_done !== 1'b1 || rq1_gnt !== 1'b1 || rq0_done !== 1'b0 || wbm_cyc_o !== 1'b0 || rd_wren !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done: done1 %b gnt1 %b done0 %b cyc %b rd_wren %b required 1 1 0 0 0",
                     rq1_done, rq1_gnt, rq0_done, wbm_cyc_o, rd_wren);
        end
        rq1_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_round_robin();
        int side;
        rq0_we = 1'b0; rq0_adr = 32'h0000_3000; rq0_len = 8'd2;
        rq1_we = 1'b1; rq1_adr = 32'h0000_4000; rq1_len = 8'd2;
        rq0_req = 1'b1; rq1_req = 1'b1; wbm_ack_i = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            side = b % 2;
            @(negedge clk_50);
            vectors++;
            if ({rq1_gnt, rq0_gnt} !== ((side == 1) ? 2'b10 : 2'b01) || wbm_cyc_o !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_grant%0d: gnt1/gnt0 %b cyc %b required %b 0", b,
                         {rq1_gnt, rq0_gnt}, wbm_cyc_o, (side == 1) ? 2'b10 : 2'b01);
            end
            step();
            @(negedge clk_50);
            vectors++;
            if (wbm_cyc_o !== 1'b1 || wbm_we_o !== side[0] ||
                wbm_adr_o !== ((side == 1) ? 32'h4000 : 32'h3000)) begin
                miscompares++;
                $display("FAIL rr_beat0_%0d: cyc %b we %b adr %h required 1 %0d %h", b,
                         wbm_cyc_o, wbm_we_o, wbm_adr_o, side, (side == 1) ? 32'h4000 : 32'h3000);
            end
            step();
            @(negedge clk_50);
            vectors++;
            if (wbm_cyc_o !== 1'b1 || wbm_cti_o !== 3'b111) begin
                miscompares++;
                $display("FAIL rr_beat1_%0d: cyc %b cti %b required 1 111", b, wbm_cyc_o, wbm_cti_o);
            end
            step();
            @(negedge clk_50);
            vectors++;
            if ({rq1_done, rq0_done} !== ((side == 1) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL rr_done%0d: done1/done0 %b required %b", b, {rq1_done, rq0_done},
                         (side == 1) ? 2'b10 : 2'b01);
            end
            step();
            @(negedge clk_50);
            vectors++;
            if ({rq1_gnt, rq0_gnt, wbm_cyc_o} !== 3'b000) begin
                miscompares++;
                $display("FAIL rr_idle%0d: gnt1/gnt0/cyc %b required 000", b, {rq1_gnt, rq0_gnt, wbm_cyc_o});
            end
            if (b == 3) begin
                rq0_req = 1'b0;
                rq1_req = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_zero_len();
        rq0_we = 1'b0; rq0_adr = 32'h0000_8000; rq0_len = 8'd0; rq0_req = 1'b1;
        step();
        @(negedge clk_50);
        vectors++;
        if (rq0_gnt !== 1'b1 || rq0_done !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL zl_grant: gnt %b done %b cyc %b required 1 0 0", rq0_gnt, rq0_done, wbm_cyc_o);
        end
        step();
        @(negedge clk_50);
        vectors++;
        if (rq0_gnt !== 1'b1 || rq0_done !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL zl_done: gnt %b done %b cyc %b required 1 1 0", rq0_gnt, rq0_done, wbm_cyc_o);
        end
        rq0_req = 1'b0;
        step();
        @(negedge clk_50);
        vectors++;
        if (rq0_gnt !== 1'b0 || rq0_done !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL zl_release: gnt %b done %b cyc %b required 0 0 0", rq0_gnt, rq0_done, wbm_cyc_o);
        end
        step();
    endtask

    task automatic test_clamp_waits();
        int beats = 0;
        int rdw   = 0;
        bit seen  = 1'b0;
        logic [6:0] exp_ba;
        rq0_we = 1'b0; rq0_adr = 32'h0000_5000; rq0_len = 8'd200; rq0_req = 1'b1;
        wbm_ack_i = 1'b0;
        step();
        step();
        for (int n = 0; n < 600 && !seen; n++) begin
            wbm_ack_i = (n % 2 == 1);
            wbm_dat_i = 32'h7700_0000 + beats;
            @(negedge clk_50);
            if (rd_wren === 1'b1) rdw++;
            if (rq0_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                exp_ba = wbm_ack_i ? 7'(beats + 1) : 7'(beats);
                vectors++;
                if (bram_addr !== exp_ba || wbm_adr_o !== 32'h5000 + 4 * beats) begin
                    miscompares++;
                    $display("FAIL cl_cycle%0d: bram_addr %0d adr %h required %0d %h", n,
                             bram_addr, wbm_adr_o, exp_ba, 32'h5000 + 4 * beats);
                end
                if (wbm_ack_i) beats++;
            end
            step();
        end
        vectors++;
        if (!seen || beats != 128) begin
            miscompares++;
            $display("FAIL cl_beats: done_seen %0d beats %0d required 1 128", seen, beats);
        end
        vectors++;
        if (rdw != 128) begin
            miscompares++;
            $display("FAIL cl_rd_wren_count: got %0d required 128", rdw);
        end
        rq0_req = 1'b0;
        wbm_ack_i = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset_mid_burst();
        rq1_we = 1'b1; rq1_adr = 32'h0000_9000; rq1_len = 8'd8; rq1_req = 1'b1;
        wbm_ack_i = 1'b1;
        step();
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rq1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50);
            vectors++;
            if ({wbm_cyc_o, wbm_stb_o, rq1_gnt, rq1_done, rq0_done} !== 5'b0) begin
                miscompares++;
                $display("FAIL rst_mid%0d: cyc/stb/gnt1/done1/done0 %b required 00000", i,
                         {wbm_cyc_o, wbm_stb_o, rq1_gnt, rq1_done, rq0_done});
            end
            step();
        end
    endtask

`ifdef SD_WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        rq0_we = 1'b0; rq0_adr = 32'h0000_6000; rq0_len = 8'd8; rq0_req = 1'b1;
        wbm_ack_i = 1'b1;
        step();
        step();
        step();
        step();
        step();
        wbm_ack_i = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk_50);
            vectors++;
            if (rq0_err !== 1'b0 || wbm_cyc_o !== 1'b1) begin
                miscompares++;
                $display("FAIL to_wait%0d: err %b cyc %b required 0 1", c, rq0_err, wbm_cyc_o);
            end
            step();
        end
        @(negedge clk_50);
        vectors++;
        if (rq0_err !== 1'b1 || rq0_done !== 1'b0 || wbm_cyc_o !== 1'b0 || rd_wren !== 1'b0) begin
            miscompares++;
            $display("FAIL to_err: err %b done %b cyc %b wren %b required 1 0 0 0",
                     rq0_err, rq0_done, wbm_cyc_o, rd_wren);
        end
        rq0_req = 1'b0;
        step();
        @(negedge clk_50);
        vectors++;
        if (rq0_gnt !== 1'b0 || rq0_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_release: gnt %b err %b required 0 0", rq0_gnt, rq0_err);
        end
        rq1_we = 1'b0; rq1_adr = 32'h0000_7000; rq1_len = 8'd1; rq1_req = 1'b1;
        wbm_ack_i = 1'b1;
        step();
        step();
        step();
        @(negedge clk_50);
        vectors++;
        if (rq1_done !== 1'b1 || rq1_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_next_grant: done1 %b err1 %b required 1 0", rq1_done, rq1_err);
        end
        rq1_req = 1'b0;
        step();
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rq0_req = 1'b0; rq0_we = 1'b0; rq0_adr = '0; rq0_len = '0;
        rq1_req = 1'b0; rq1_we = 1'b0; rq1_adr = '0; rq1_len = '0;
        wbm_ack_i = 1'b0; wbm_dat_i = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        test_reset();
        test_read_burst();
        test_write_burst();
        test_round_robin();
        test_zero_len();
        test_clamp_waits();
        test_reset_mid_burst();
`ifdef SD_WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
